// File: rtl/mem_stage_ws_if.sv
// EX/MEM -> MEM/WB bundle for the wait-state memory stage.
// master drives the EX/MEM slot, slave is the stage itself.
interface mem_stage_ws_if #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 4
);
  logic              in_valid;
  logic              branch;
  logic              branch_ne;
  logic              mem_read;
  logic              mem_write;
  logic              reg_write;
  logic              memto_reg;
  logic              alu_zero;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] store_data;
  logic [DATA_W-1:0] branch_target;
  logic [RA_W-1:0]   dest_reg;

  logic              pc_src;
  logic [DATA_W-1:0] branch_target_out;
  logic              stall;
  logic              wb_valid;
  logic              wb_reg_write;
  logic              wb_memto_reg;
  logic [DATA_W-1:0] wb_read_data;
  logic [DATA_W-1:0] wb_alu_result;
  logic [RA_W-1:0]   wb_dest_reg;
  logic              wb_fault;

  modport master (
    output in_valid, branch, branch_ne,
    output mem_read, mem_write, reg_write,
    output memto_reg, alu_zero, alu_result,
    output store_data, branch_target, dest_reg,
    input  pc_src, branch_target_out, stall,
    input  wb_valid, wb_reg_write, wb_memto_reg,
    input  wb_read_data, wb_alu_result,
    input  wb_dest_reg, wb_fault
  );

  modport slave (
    input  in_valid, branch, branch_ne,
    input  mem_read, mem_write, reg_write,
    input  memto_reg, alu_zero, alu_result,
    input  store_data, branch_target, dest_reg,
    output pc_src, branch_target_out, stall,
    output wb_valid, wb_reg_write, wb_memto_reg,
    output wb_read_data, wb_alu_result,
    output wb_dest_reg, wb_fault
  );
endinterface

// File: rtl/mem_stage_ws.sv
// MEM stage: data RAM with wait states, branch resolve,
// address-fault detection and the MEM/WB register.
module mem_stage_ws #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1,
  parameter int RA_W        = 4
) (
  input logic           clk,
  input logic           rst_n,
  mem_stage_ws_if.slave bus
);
  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  localparam bit HAS_WAIT = WAIT_STATES > 0;
  localparam logic [2:0] WS_M1 =
    3'(HAS_WAIT ? WAIT_STATES - 1 : 0);

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic              stall_i;
  logic              done;
  logic              access;
  logic              fault;
  logic              flt;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  assign access = bus.in_valid &
                  (bus.mem_read | bus.mem_write);
  assign addr   = bus.alu_result[ADDR_W-1:0];
  assign fault  = |bus.alu_result[DATA_W-1:ADDR_W];
  assign flt    = access & fault;
  assign done   = ~stall_i;
  assign we     = rst_n & done & access &
                  bus.mem_write & ~fault;
  // Read sees the pre-write word when both strobes are set
  assign rdata  = (access & bus.mem_read & ~fault) ?
                  mem[addr] : '0;

  assign bus.stall  = rst_n & stall_i;
  assign bus.pc_src = rst_n & bus.in_valid & bus.branch &
                      (bus.alu_zero ^ bus.branch_ne) &
                      ~stall_i;
  assign bus.branch_target_out = bus.branch_target;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_i   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (access && HAS_WAIT) begin
          stall_i   = 1'b1;
          state_nxt = S_WAIT;
          cnt_nxt   = WS_M1;
        end
      end
      S_WAIT: begin
        if (cnt != 3'd0) begin
          stall_i = 1'b1;
          cnt_nxt = cnt - 3'd1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= bus.store_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      cnt               <= '0;
      bus.wb_valid      <= 1'b0;
      bus.wb_reg_write  <= 1'b0;
      bus.wb_memto_reg  <= 1'b0;
      bus.wb_read_data  <= '0;
      bus.wb_alu_result <= '0;
      bus.wb_dest_reg   <= '0;
      bus.wb_fault      <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (done) begin
        bus.wb_valid      <= bus.in_valid;
        bus.wb_reg_write  <= bus.in_valid &
                             bus.reg_write & ~flt;
        bus.wb_memto_reg  <= bus.memto_reg;
        bus.wb_read_data  <= rdata;
        bus.wb_alu_result <= bus.alu_result;
        bus.wb_dest_reg   <= bus.dest_reg;
        bus.wb_fault      <= flt;
      end else begin
        bus.wb_valid      <= 1'b0;
        bus.wb_reg_write  <= 1'b0;
        bus.wb_memto_reg  <= 1'b0;
        bus.wb_read_data  <= '0;
        bus.wb_alu_result <= '0;
        bus.wb_dest_reg   <= '0;
        bus.wb_fault      <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_ws.sv
// Scoreboard bench for mem_stage_ws at 0, 1 and 3 wait
// states; one shared stimulus bus, per-DUT monitors.
module tb_mem_stage_ws;
  typedef struct packed {
    logic [15:0] rd;
    logic [15:0] alu;
    logic [3:0]  dst;
    logic        rw;
    logic        flt;
  } wb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   sel = 1;
  int   checks = 0;
  int   errors = 0;

  logic        v, br, bne, mr, mw, rw, m2r, az;
  logic [15:0] alu, sd, bt;
  logic [3:0]  dr;

  wb_t q0[$], q1[$], q3[$];
  wb_t g0, g1, g3;

  always #5 clk = ~clk;

  mem_stage_ws_if #(.DATA_W(16), .RA_W(4)) b0();
  mem_stage_ws_if #(.DATA_W(16), .RA_W(4)) b1();
  mem_stage_ws_if #(.DATA_W(16), .RA_W(4)) b3();

  mem_stage_ws #(.WAIT_STATES(0)) d0 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  mem_stage_ws #(.WAIT_STATES(1)) d1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));
  mem_stage_ws #(.WAIT_STATES(3)) d3 (
    .clk(clk), .rst_n(rst_n), .bus(b3));

  assign b0.in_valid = v && sel == 0;
  assign b1.in_valid = v && sel == 1;
  assign b3.in_valid = v && sel == 3;
  assign {b0.branch, b1.branch, b3.branch} = {3{br}};
  assign {b0.branch_ne, b1.branch_ne, b3.branch_ne} = {3{bne}};
  assign {b0.mem_read, b1.mem_read, b3.mem_read} = {3{mr}};
  assign {b0.mem_write, b1.mem_write, b3.mem_write} = {3{mw}};
  assign {b0.reg_write, b1.reg_write, b3.reg_write} = {3{rw}};
  assign {b0.memto_reg, b1.memto_reg, b3.memto_reg} = {3{m2r}};
  assign {b0.alu_zero, b1.alu_zero, b3.alu_zero} = {3{az}};
  assign {b0.alu_result, b1.alu_result, b3.alu_result} = {3{alu}};
  assign {b0.store_data, b1.store_data, b3.store_data} = {3{sd}};
  assign {b0.branch_target, b1.branch_target,
          b3.branch_target} = {3{bt}};
  assign {b0.dest_reg, b1.dest_reg, b3.dest_reg} = {3{dr}};

  logic        cur_stall, cur_pc;
  logic [15:0] cur_bt;
  always_comb begin
    cur_stall = b3.stall;
    cur_pc    = b3.pc_src;
    cur_bt    = b3.branch_target_out;
    if (sel == 0) begin
      cur_stall = b0.stall;
      cur_pc    = b0.pc_src;
      cur_bt    = b0.branch_target_out;
    end else if (sel == 1) begin
      cur_stall = b1.stall;
      cur_pc    = b1.pc_src;
      cur_bt    = b1.branch_target_out;
    end
  end

  function automatic void chk(string nm, logic [63:0] a,
                              logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, a, e);
    end
  endfunction

  function automatic void cmp_wb(string nm, wb_t g, wb_t e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s wb got rd=%h alu=%h dst=%h rw=%b f=%b exp rd=%h alu=%h dst=%h rw=%b f=%b",
               nm, g.rd, g.alu, g.dst, g.rw, g.flt,
               e.rd, e.alu, e.dst, e.rw, e.flt);
    end
  endfunction

  function automatic void extra(string nm, logic [15:0] a);
    checks++;
    errors++;
    $display("FAIL %s unexpected wb entry got alu=%h exp none",
             nm, a);
  endfunction

  always @(negedge clk) if (rst_n && b0.wb_valid) begin
    g0 = '{b0.wb_read_data, b0.wb_alu_result,
           b0.wb_dest_reg, b0.wb_reg_write, b0.wb_fault};
    if (q0.size() == 0) extra("d0", g0.alu);
    else cmp_wb("d0", g0, q0.pop_front());
  end
  always @(negedge clk) if (rst_n && b1.wb_valid) begin
    g1 = '{b1.wb_read_data, b1.wb_alu_result,
           b1.wb_dest_reg, b1.wb_reg_write, b1.wb_fault};
    if (q1.size() == 0) extra("d1", g1.alu);
    else cmp_wb("d1", g1, q1.pop_front());
  end
  always @(negedge clk) if (rst_n && b3.wb_valid) begin
    g3 = '{b3.wb_read_data, b3.wb_alu_result,
           b3.wb_dest_reg, b3.wb_reg_write, b3.wb_fault};
    if (q3.size() == 0) extra("d3", g3.alu);
    else cmp_wb("d3", g3, q3.pop_front());
  end

  function automatic void push(wb_t e);
    if (sel == 0) q0.push_back(e);
    else if (sel == 1) q1.push_back(e);
    else q3.push_back(e);
  endfunction

  task automatic clear();
    v = 0; br = 0; bne = 0; mr = 0; mw = 0; rw = 0;
    m2r = 0; az = 0; alu = 0; sd = 0; bt = 0; dr = 0;
  endtask

  task automatic idle();
    clear();
    @(posedge clk); #1;
  endtask

  // Called just after a rising edge; returns the same way.
  task automatic issue(input logic r, input logic w,
                       input logic [15:0] a,
                       input logic [15:0] d,
                       input logic [3:0] dst,
                       input logic rwi, input int est,
                       input logic [15:0] erd,
                       input logic ef, input string nm);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    v = 1; br = 0; mr = r; mw = w; rw = rwi; m2r = r;
    alu = a; sd = d; dr = dst;
    push('{erd, a, dst, rwi & ~ef, ef});
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (cur_stall) n++;
      else done = 1;
      @(posedge clk); #1;
    end
    if (!done) chk({nm, "_timeout"}, 1, 0);
    chk({nm, "_stall_cycles"}, 64'(n), 64'(est));
  endtask

  task automatic chk_rst(string nm, mem_stage_ws_if b);
  endtask

  task automatic br_case(input logic vi, input logic z,
                         input logic ne, input logic e,
                         input string nm);
    v = vi; br = 1; bne = ne; az = z; mr = 0; mw = 0;
    rw = 0; alu = 16'h0000; bt = 16'h4A00 + 16'(checks);
    dr = 0;
    if (vi) push('{16'h0, 16'h0, 4'h0, 1'b0, 1'b0});
    @(negedge clk);
    chk({nm, "_pc_src"}, 64'(cur_pc), 64'(e));
    chk({nm, "_stall"}, 64'(cur_stall), 0);
    chk({nm, "_bt_out"}, 64'(cur_bt), 64'(bt));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    clear();
    rst_n = 0;
    v = 1; br = 1; az = 1; mr = 1;
    alu = 16'h0012;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc_src", {b0.pc_src, b1.pc_src, b3.pc_src}, 0);
    chk("rst_stall", {b0.stall, b1.stall, b3.stall}, 0);
    clear();
    @(posedge clk); #1;
    rst_n = 1;
    chk("rst_wb_d0", {b0.wb_valid, b0.wb_reg_write,
        b0.wb_memto_reg, b0.wb_read_data,
        b0.wb_alu_result, b0.wb_dest_reg, b0.wb_fault}, 0);
    chk("rst_wb_d1", {b1.wb_valid, b1.wb_reg_write,
        b1.wb_memto_reg, b1.wb_read_data,
        b1.wb_alu_result, b1.wb_dest_reg, b1.wb_fault}, 0);
    chk("rst_wb_d3", {b3.wb_valid, b3.wb_reg_write,
        b3.wb_memto_reg, b3.wb_read_data,
        b3.wb_alu_result, b3.wb_dest_reg, b3.wb_fault}, 0);

    sel = 1;
    issue(0, 1, 16'h0012, 16'hBEEF, 4'd0, 0, 1,
          16'h0000, 0, "ws1_st");
    issue(1, 0, 16'h0012, 16'h0000, 4'd3, 1, 1,
          16'hBEEF, 0, "ws1_ld");
    idle();

    sel = 3;
    issue(0, 1, 16'h0007, 16'h5555, 4'd0, 0, 3,
          16'h0000, 0, "ws3_st");
    issue(1, 0, 16'h0007, 16'h0000, 4'd4, 1, 3,
          16'h5555, 0, "ws3_ld");
    idle();
    @(negedge clk);
    chk("ws3_idle_stall", 64'(b3.stall), 0);
    @(posedge clk); #1;

    sel = 0;
    issue(0, 1, 16'h0005, 16'h1234, 4'd0, 0, 0,
          16'h0000, 0, "ws0_st");
    issue(1, 0, 16'h0005, 16'h0000, 4'd5, 1, 0,
          16'h1234, 0, "ws0_ld");
    issue(1, 1, 16'h0005, 16'h9999, 4'd6, 0, 0,
          16'h1234, 0, "ws0_rw");
    issue(1, 0, 16'h0005, 16'h0000, 4'd7, 1, 0,
          16'h9999, 0, "ws0_ld2");
    idle();

    sel = 1;
    br_case(1, 1, 0, 1, "br_z_eq");
    br_case(1, 1, 1, 0, "br_z_ne");
    br_case(1, 0, 0, 0, "br_nz_eq");
    br_case(1, 0, 1, 1, "br_nz_ne");
    br_case(0, 1, 0, 0, "br_invalid");
    idle();

    issue(0, 1, 16'h0000, 16'h0F0F, 4'd0, 0, 1,
          16'h0000, 0, "flt_pre");
    issue(1, 0, 16'h0100, 16'h0000, 4'd8, 1, 1,
          16'h0000, 1, "flt_ld");
    issue(0, 1, 16'h0100, 16'hDEAD, 4'd0, 0, 1,
          16'h0000, 1, "flt_st");
    issue(1, 0, 16'h0000, 16'h0000, 4'd9, 1, 1,
          16'h0F0F, 0, "flt_chk");
    idle();
    repeat (2) idle();

    sel = 3;
    v = 1; mw = 1; alu = 16'h0007; sd = 16'hAAAA;
    @(negedge clk);
    chk("abort_stall1", 64'(b3.stall), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_stall2", 64'(b3.stall), 1);
    rst_n = 0;
    clear();
    #1;
    chk("abort_rst_stall", 64'(b3.stall), 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1;
    chk("abort_wb_d3", {b3.wb_valid, b3.wb_reg_write,
        b3.wb_memto_reg, b3.wb_read_data,
        b3.wb_alu_result, b3.wb_dest_reg, b3.wb_fault}, 0);
    issue(1, 0, 16'h0007, 16'h0000, 4'd2, 1, 3,
          16'h5555, 0, "abort_ld");
    repeat (3) idle();

    chk("q0_drained", 64'(q0.size()), 0);
    chk("q1_drained", 64'(q1.size()), 0);
    chk("q3_drained", 64'(q3.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
